// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared bullet colour codes, field slices and collider states
package bullet_pkg;

    localparam logic [1:0] COLOR_WHITE = 2'b00;
    localparam logic [1:0] COLOR_GREEN = 2'b01;
    localparam logic [1:0] COLOR_BLUE  = 2'b10;
    localparam logic [1:0] COLOR_NONE  = 2'b11;

    // position packs {x, y}, size packs {width, height}
    localparam int X_HI = 15;
    localparam int X_LO = 8;
    localparam int Y_HI = 7;
    localparam int Y_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HIT   = 2'd2,
        S_DONE  = 2'd3
    } collider_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - strict axis-aligned box overlap test between two boxes
module aabb_overlap
    import bullet_pkg::*;
(
    input  logic [15:0] i_pos_a,
    input  logic [15:0] i_size_a,
    input  logic [15:0] i_pos_b,
    input  logic [15:0] i_size_b,
    output logic        o_overlap
);

    logic [8:0] w_ax, w_ay, w_aw, w_ah;
    logic [8:0] w_bx, w_by, w_bw, w_bh;
    logic       w_nonzero;

    assign w_ax = {1'b0, i_pos_a[X_HI:X_LO]};
    assign w_ay = {1'b0, i_pos_a[Y_HI:Y_LO]};
    assign w_aw = {1'b0, i_size_a[X_HI:X_LO]};
    assign w_ah = {1'b0, i_size_a[Y_HI:Y_LO]};
    assign w_bx = {1'b0, i_pos_b[X_HI:X_LO]};
    assign w_by = {1'b0, i_pos_b[Y_HI:Y_LO]};
    assign w_bw = {1'b0, i_size_b[X_HI:X_LO]};
    assign w_bh = {1'b0, i_size_b[Y_HI:Y_LO]};

    // A degenerate box sitting strictly inside the other would otherwise pass
    assign w_nonzero = (w_aw != 9'd0) && (w_ah != 9'd0) && (w_bw != 9'd0) && (w_bh != 9'd0);

    assign o_overlap = w_nonzero
                    && (w_ax < w_bx + w_bw) && (w_bx < w_ax + w_aw)
                    && (w_ay < w_by + w_bh) && (w_by < w_ay + w_ah);

endmodule

// File: rtl/bullet_collider.sv
// rtl/bullet_collider.sv - per-frame bullet scan, hit clearing and player HP tracking
module bullet_collider
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS   = 3,
    parameter int HP_MAX        = 100,
    parameter int DMG_WHITE     = 5,
    parameter int DMG_BLUE      = 5,
    parameter int HEAL_GREEN    = 2,
    parameter int INVULN_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isRun,
    input  logic        tick,
    output logic [2:0]  index,
    input  logic [15:0] position,
    input  logic [15:0] size,
    input  logic [1:0]  color,
    input  logic        isRender,
    input  logic [15:0] playerPosition,
    input  logic [15:0] playerSize,
    input  logic        playerMoving,
    output logic        isCollide,
    output logic [7:0]  hp,
    output logic        isDead,
    output logic        scanDone
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_BULLETS - 1);

    collider_state_t r_state, w_state_nx;
    logic [2:0]      r_index, w_index_nx;
    logic [7:0]      r_hp, w_hp_nx;
    logic [3:0]      r_inv, w_inv_nx;
    logic            r_dmg_scan, w_dmg_scan_nx;

    logic       w_overlap, w_hit, w_last;
    logic [7:0] w_hp_white, w_hp_blue, w_hp_green;
    logic [8:0] w_hp_heal;

    aabb_overlap u_overlap (
        .i_pos_a   (position),
        .i_size_a  (size),
        .i_pos_b   (playerPosition),
        .i_size_b  (playerSize),
        .o_overlap (w_overlap)
    );

    assign w_hit  = isRender && w_overlap && (color != COLOR_NONE);
    assign w_last = (r_index == LAST_IDX);

    assign w_hp_white = (r_hp < 8'(DMG_WHITE)) ? 8'd0 : r_hp - 8'(DMG_WHITE);
    assign w_hp_blue  = (r_hp < 8'(DMG_BLUE))  ? 8'd0 : r_hp - 8'(DMG_BLUE);
    assign w_hp_heal  = {1'b0, r_hp} + 9'(HEAL_GREEN);
    assign w_hp_green = (w_hp_heal > 9'(HP_MAX)) ? 8'(HP_MAX) : w_hp_heal[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_index    <= 3'd0;
            r_hp       <= 8'(HP_MAX);
            r_inv      <= 4'd0;
            r_dmg_scan <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_index    <= w_index_nx;
            r_hp       <= w_hp_nx;
            r_inv      <= w_inv_nx;
            r_dmg_scan <= w_dmg_scan_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_index_nx    = r_index;
        w_hp_nx       = r_hp;
        w_inv_nx      = r_inv;
        w_dmg_scan_nx = r_dmg_scan;
        if (!isRun) begin
            w_state_nx    = S_IDLE;
            w_index_nx    = 3'd0;
            w_hp_nx       = 8'(HP_MAX);
            w_inv_nx      = 4'd0;
            w_dmg_scan_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tick && (r_hp != 8'd0)) begin
                        w_state_nx    = S_CHECK;
                        w_index_nx    = 3'd0;
                        w_dmg_scan_nx = 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        w_state_nx = S_HIT;
                    end else if (w_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_index_nx = r_index + 3'd1;
                    end
                end
                S_HIT: begin
                    if (color == COLOR_GREEN) begin
                        w_hp_nx = w_hp_green;
                    end else if ((r_inv == 4'd0) && (color == COLOR_WHITE)) begin
                        w_hp_nx       = w_hp_white;
                        w_inv_nx      = 4'(INVULN_FRAMES);
                        w_dmg_scan_nx = 1'b1;
                    end else if ((r_inv == 4'd0) && (color == COLOR_BLUE) && playerMoving) begin
                        w_hp_nx       = w_hp_blue;
                        w_inv_nx      = 4'(INVULN_FRAMES);
                        w_dmg_scan_nx = 1'b1;
                    end
                    if (w_last) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_CHECK;
                        w_index_nx = r_index + 3'd1;
                    end
                end
                S_DONE: begin
                    // The scan that armed the counter does not consume one of its frames
                    if ((r_inv != 4'd0) && !r_dmg_scan) begin
                        w_inv_nx = r_inv - 4'd1;
                    end
                    w_state_nx = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    assign index     = r_index;
    assign hp        = r_hp;
    assign isCollide = (r_state == S_HIT);
    assign scanDone  = (r_state == S_DONE);
    assign isDead    = (r_hp == 8'd0);

endmodule

// File: tb/tb_bullet_collider.sv
// tb/tb_bullet_collider.sv - directed self-checking bench for bullet_collider
module tb_bullet_collider;

    logic        clk = 1'b0;
    logic        reset, isRun, tick;
    logic [2:0]  index;
    logic [15:0] position, size;
    logic [1:0]  color;
    logic        isRender;
    logic [15:0] playerPosition, playerSize;
    logic        playerMoving;
    logic        isCollide, isDead, scanDone;
    logic [7:0]  hp;

    logic [15:0] s_pos [3];
    logic [15:0] s_size[3];
    logic [1:0]  s_col [3];
    logic        s_ren [3];

    int n_cmp = 0;
    int n_err = 0;
    int ncol, cidx, dcyc;

    always #5 clk = ~clk;

    always_comb begin
        if (index < 3'd3) begin
            position = s_pos[index];
            size     = s_size[index];
            color    = s_col[index];
            isRender = s_ren[index];
        end else begin
            position = 16'h0;
            size     = 16'h0;
            color    = 2'b11;
            isRender = 1'b0;
        end
    end

    bullet_collider dut (
        .clk            (clk),
        .reset          (reset),
        .isRun          (isRun),
        .tick           (tick),
        .index          (index),
        .position       (position),
        .size           (size),
        .color          (color),
        .isRender       (isRender),
        .playerPosition (playerPosition),
        .playerSize     (playerSize),
        .playerMoving   (playerMoving),
        .isCollide      (isCollide),
        .hp             (hp),
        .isDead         (isDead),
        .scanDone       (scanDone)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 3; i++) begin
            s_pos[i] = 16'h0; s_size[i] = 16'h0; s_col[i] = 2'b11; s_ren[i] = 1'b0;
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] p, input logic [15:0] s, input logic [1:0] c);
        s_pos[i] = p; s_size[i] = s; s_col[i] = c; s_ren[i] = 1'b1;
    endtask

    // Pulses tick, then follows the scan at negedges; cycle 1 is the first CHECK cycle
    task automatic scan(output int n_col, output int col_idx, output int done_cyc);
        int cyc;
        n_col = 0; col_idx = 7; done_cyc = 0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        cyc = 1;
        while (cyc < 20) begin
            if (isCollide) begin n_col++; col_idx = int'(index); end
            if (scanDone) begin done_cyc = cyc; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic blanks(input int n);
        int a, b, c;
        clear_slots();
        for (int k = 0; k < n; k++) scan(a, b, c);
    endtask

    task automatic white_round();
        int a, b, c;
        clear_slots();
        set_slot(1, 16'h8888, 16'h1010, 2'b00);
        scan(a, b, c);
        blanks(4);
    endtask

    initial begin
        reset = 1'b1; isRun = 1'b1; tick = 1'b0; playerMoving = 1'b0;
        playerPosition = 16'h8080; playerSize = 16'h1010;
        clear_slots();
        #12;
        check("rst_index", 16'(index), 16'd0);
        check("rst_collide", 16'(isCollide), 16'd0);
        check("rst_done", 16'(scanDone), 16'd0);
        check("rst_hp", 16'(hp), 16'd100);
        check("rst_dead", 16'(isDead), 16'd0);
        @(negedge clk); reset = 1'b0;

        scan(ncol, cidx, dcyc);
        check("empty_ncol", 16'(ncol), 16'd0);
        check("empty_done_cyc", 16'(dcyc), 16'd4);

        set_slot(1, 16'h8888, 16'h1010, 2'b00);
        scan(ncol, cidx, dcyc);
        check("white_ncol", 16'(ncol), 16'd1);
        check("white_idx", 16'(cidx), 16'd1);
        check("white_done_cyc", 16'(dcyc), 16'd5);
        check("white_hp", 16'(hp), 16'd95);

        for (int k = 0; k < 4; k++) begin
            scan(ncol, cidx, dcyc);
            check("invuln_ncol", 16'(ncol), 16'd1);
            check("invuln_hp", 16'(hp), 16'd95);
        end
        scan(ncol, cidx, dcyc);
        check("sixth_hp", 16'(hp), 16'd90);

        @(negedge clk); isRun = 1'b0;
        @(negedge clk); isRun = 1'b1;
        check("norun_hp", 16'(hp), 16'd100);

        clear_slots();
        set_slot(2, 16'h8888, 16'h1010, 2'b10);
        scan(ncol, cidx, dcyc);
        check("blue_still_ncol", 16'(ncol), 16'd1);
        check("blue_still_idx", 16'(cidx), 16'd2);
        check("blue_still_hp", 16'(hp), 16'd100);
        playerMoving = 1'b1;
        scan(ncol, cidx, dcyc);
        check("blue_moving_hp", 16'(hp), 16'd95);
        playerMoving = 1'b0;

        clear_slots();
        set_slot(0, 16'h7878, 16'h1010, 2'b01);
        scan(ncol, cidx, dcyc);
        check("green1_hp", 16'(hp), 16'd97);
        scan(ncol, cidx, dcyc);
        check("green2_hp", 16'(hp), 16'd99);
        scan(ncol, cidx, dcyc);
        check("green_cap_hp", 16'(hp), 16'd100);

        clear_slots();
        set_slot(0, 16'h9080, 16'h1010, 2'b00);
        set_slot(1, 16'h8070, 16'h1010, 2'b00);
        set_slot(2, 16'h8484, 16'h0010, 2'b00);
        scan(ncol, cidx, dcyc);
        check("edge_zero_ncol", 16'(ncol), 16'd0);
        check("edge_zero_done", 16'(dcyc), 16'd4);
        clear_slots();
        set_slot(1, 16'h8888, 16'h1010, 2'b11);
        scan(ncol, cidx, dcyc);
        check("inert_ncol", 16'(ncol), 16'd0);

        @(negedge clk); isRun = 1'b0;
        @(negedge clk); isRun = 1'b1;
        white_round();
        white_round();
        check("two_whites_hp", 16'(hp), 16'd90);
        clear_slots();
        set_slot(0, 16'h8888, 16'h1010, 2'b01);
        set_slot(1, 16'h8888, 16'h1010, 2'b01);
        set_slot(2, 16'h8888, 16'h1010, 2'b01);
        scan(ncol, cidx, dcyc);
        check("triple_green_ncol", 16'(ncol), 16'd3);
        check("triple_green_hp", 16'(hp), 16'd96);
        clear_slots();
        set_slot(0, 16'h8888, 16'h1010, 2'b01);
        scan(ncol, cidx, dcyc);
        check("green_98_hp", 16'(hp), 16'd98);
        for (int k = 0; k < 19; k++) white_round();
        check("low_hp", 16'(hp), 16'd3);
        check("low_dead", 16'(isDead), 16'd0);
        white_round();
        check("dead_hp", 16'(hp), 16'd0);
        check("dead_flag", 16'(isDead), 16'd1);

        set_slot(1, 16'h8888, 16'h1010, 2'b01);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        ncol = 0; dcyc = 0;
        for (int k = 0; k < 8; k++) begin
            if (isCollide) ncol++;
            if (scanDone) dcyc++;
            @(negedge clk);
        end
        check("dead_no_collide", 16'(ncol), 16'd0);
        check("dead_no_done", 16'(dcyc), 16'd0);
        check("dead_sticky", 16'(isDead), 16'd1);

        isRun = 1'b0;
        @(negedge clk); isRun = 1'b1;
        check("revive_hp", 16'(hp), 16'd100);
        check("revive_dead", 16'(isDead), 16'd0);

        clear_slots();
        set_slot(0, 16'h8888, 16'h1010, 2'b00);
        scan(ncol, cidx, dcyc);
        check("pre_reset_hp", 16'(hp), 16'd95);
        clear_slots();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        check("mid_scan_index", 16'(index), 16'd1);
        #1 reset = 1'b1;
        #1;
        check("async_index", 16'(index), 16'd0);
        check("async_collide", 16'(isCollide), 16'd0);
        check("async_done", 16'(scanDone), 16'd0);
        check("async_hp", 16'(hp), 16'd100);
        @(negedge clk); reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
